multi_lane_deskew_buffer: RTL and testbench
===========================================

Name: multi_lane_deskew_buffer

Overview:
Single-clock, multi-lane deskew buffer in the receive PHY. It sits after the per-lane elastic buffers, on the local read_clk domain. Each lane has its own FIFO. The block hunts for the K28.5 COM symbol on every lane and releases all lanes together once every lane has COM at its head. It then checks alignment continuously and re-hunts if lanes fall out of step.

Parameters:
DATA_WIDTH, 10, symbol width (8b/10b code group)
NUM_LANES, 4, number of lanes
BUFFER_DEPTH, 8, per-lane FIFO depth (power of 2); maximum tolerated skew is BUFFER_DEPTH-1 symbols
ERR_LIMIT, 3, number of consecutive failed hunts before sticky lock_fail is set

Ports:
read_clk  input  1  single clock for the whole block
rst  input  1  synchronous reset, active-high
data_in  input  NUM_LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
valid_in  input  NUM_LANES  per-lane symbol valid (low during upstream SKP bubbles)
deskew_en  input  1  0 = flush and hold in IDLE
data_out  output  NUM_LANES*DATA_WIDTH  aligned symbols, registered
valid_out  output  1  data_out holds one aligned symbol per lane
aligned  output  1  FSM is in ALIGNED
deskew_error  output  1  one-cycle pulse on overflow or misalignment
lock_fail  output  1  sticky until rst or deskew_en falls

Behaviour:
- Reset (rst=1 at a read_clk edge):
  - all FIFOs empty; FSM in IDLE.
  - data_out=0, valid_out=0, aligned=0, deskew_error=0, lock_fail=0, fail counter=0.
- COM detect: a head symbol is COM if it equals 10'b0011111010 (RD-) or 10'b1100000101 (RD+).
- FIFO write: lane i writes when valid_in[i]=1 and the lane is not full. A written symbol is visible at the head on the next cycle.
- FIFO read: pop and push in the same cycle are allowed at any count. Pointers are log2(BUFFER_DEPTH)+1 bits wide, with the MSB used for the full/empty wrap flag.
- IDLE:
  - FIFOs held empty, writes ignored.
  - Moves to HUNT when deskew_en=1.
- HUNT:
  - A lane whose head is non-COM is popped and the symbol discarded.
  - A lane whose head is COM holds (no pop) and keeps writing.
  - When every lane is non-empty with COM at its head, move to ALIGNED on the next cycle.
  - If any holding lane is full while its valid_in=1:
    - pulse deskew_error;
    - flush all FIFOs;
    - increment the fail counter;
    - stay in HUNT.
  - When the fail counter reaches ERR_LIMIT, set lock_fail. Hunting continues.
- ALIGNED:
  - aligned=1; the fail counter is cleared on entry.
  - When all lanes are non-empty, pop every lane together and register the heads into data_out with valid_out=1 on the next cycle (1-cycle read latency).
  - Otherwise valid_out=0 and no lane is popped.
  - Misalignment: among the popped heads, COM appears on at least one lane but not all. Action: pulse deskew_error, discard that output (valid_out=0), flush, go to HUNT.
  - Overflow: any lane full with valid_in=1. Action: same as misalignment.
- Minimum write-to-output latency in ALIGNED: 2 cycles.
- deskew_en falling in any state: return to IDLE next cycle, flush, clear lock_fail. valid_out=0 from that cycle onward.
- rst mid-operation overrides everything and gives the reset values on the next edge.
- Simultaneous events: overflow and misalignment in the same cycle produce one deskew_error pulse.

Optional Feature:
Macro DESKEW_STATS_EN.
- Defined: adds output lane_skew [NUM_LANES*($clog2(BUFFER_DEPTH)+1)].
  - On the HUNT→ALIGNED transition it captures each lane's FIFO occupancy minus the minimum occupancy across lanes.
  - Value is held until the next alignment; reset value 0.
- Undefined: no port and no capture logic.

Decomposition:
- Package deskew_pkg:
  - COM_RDN and COM_RDP constants.
  - State enum {IDLE, HUNT, ALIGNED}.
  - is_com function.
- Sub-module deskew_lane_fifo, instantiated NUM_LANES times via generate:
  - synchronous FIFO;
  - push, pop and flush inputs;
  - combinational head, count, full and empty outputs.

Test Plan:
1. Zero skew: COM on all 4 lanes in cycle 5, then incrementing data → aligned=1, first valid_out carries 4×COM, data order preserved, no deskew_error.
2. Skew {0,2,5,1} symbols, COM every 16 symbols → aligned=1. Each output word has matching symbol indices across lanes. With DESKEW_STATS_EN, lane_skew={5,3,0,4} (lane_skew is occupancy minus the minimum occupancy, so a later-arriving lane shows less).
3. Skew of 8 on lane 3 with BUFFER_DEPTH=8 → deskew_error pulses. Re-hunt repeats, and lock_fail=1 after the 3rd failure.
4. After lock, lane 2 drops one symbol → next COM appears on lanes 0, 1, 3 only. Result: a one-cycle deskew_error pulse, aligned=0, and alignment is regained at the following COM.
5. valid_in[1] held low for 3 cycles while ALIGNED → valid_out=0 for those cycles, no error, and all lanes stay in step afterward.
6. rst=1 and, separately, deskew_en=0 mid-stream → all outputs reach reset values on the next edge and FIFOs are emptied.

Source files
------------

// File: rtl/deskew_pkg.sv
// Shared definitions for the multi-lane deskew buffer: COM code groups,
// the deskew FSM state type and the COM detector.
package deskew_pkg;

    localparam logic [9:0] COM_RDN = 10'b0011111010;
    localparam logic [9:0] COM_RDP = 10'b1100000101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HUNT    = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    function automatic logic is_com(input logic [9:0] sym);
        return (sym == COM_RDN) || (sym == COM_RDP);
    endfunction

endpackage

// File: rtl/deskew_lane_fifo.sv
// Per-lane synchronous FIFO with wrap-bit pointers; head, count, full and
// empty are combinational so the deskew FSM can act on them in the same cycle.
module deskew_lane_fifo #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_flush,
    input  logic                            i_push,
    input  logic                            i_pop,
    input  logic [DATA_WIDTH-1:0]           i_din,
    output logic [DATA_WIDTH-1:0]           o_head,
    output logic [$clog2(BUFFER_DEPTH):0]   o_count,
    output logic                            o_full,
    output logic                            o_empty
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic                  w_push;
    logic                  w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    // A full lane may still accept a symbol when it is popped in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/multi_lane_deskew_buffer.sv
// Multi-lane deskew: hunts COM on every lane and releases all lanes together.
// Optional macro DESKEW_STATS_EN adds the lane_skew occupancy snapshot output.
//
// state   | meaning
// IDLE    | FIFOs held empty, waiting for deskew_en
// HUNT    | discard non-COM heads, hold lanes showing COM until all agree
// ALIGNED | pop all lanes together, watch for overflow and COM disagreement
module multi_lane_deskew_buffer
    import deskew_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int NUM_LANES    = 4,
    parameter int BUFFER_DEPTH = 8,
    parameter int ERR_LIMIT    = 3
) (
    input  logic                             read_clk,
    input  logic                             rst,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  data_in,
    input  logic [NUM_LANES-1:0]             valid_in,
    input  logic                             deskew_en,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  data_out,
    output logic                             valid_out,
    output logic                             aligned,
    output logic                             deskew_error,
    output logic                             lock_fail
`ifdef DESKEW_STATS_EN
    ,
    output logic [NUM_LANES*($clog2(BUFFER_DEPTH)+1)-1:0] lane_skew
`endif
);

    localparam int CW = $clog2(BUFFER_DEPTH) + 1;
    localparam int FW = $clog2(ERR_LIMIT + 1);

    state_t                          r_state;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_data_out;
    logic                            r_valid_out;
    logic                            r_aligned;
    logic                            r_deskew_error;
    logic                            r_lock_fail;
    logic [FW-1:0]                   r_fail_cnt;

    logic [DATA_WIDTH-1:0] w_head  [NUM_LANES];
    logic [CW-1:0]         w_count [NUM_LANES];
    logic [CW-1:0]         w_min_count;
    logic [NUM_LANES-1:0]  w_full;
    logic [NUM_LANES-1:0]  w_empty;
    logic [NUM_LANES-1:0]  w_com;
    logic [NUM_LANES-1:0]  w_push;
    logic [NUM_LANES-1:0]  w_pop;
    logic                  w_all_ready;
    logic                  w_all_com;
    logic                  w_hold_ovf;
    logic                  w_ovf;
    logic                  w_misalign;
    logic                  w_hunt_err;
    logic                  w_aligned_err;
    logic                  w_flush;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        deskew_lane_fifo #(
            .DATA_WIDTH   (DATA_WIDTH),
            .BUFFER_DEPTH (BUFFER_DEPTH)
        ) u_fifo (
            .i_clk   (read_clk),
            .i_rst   (rst),
            .i_flush (w_flush),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_din   (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_head  (w_head[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g])
        );
        assign w_com[g] = ~w_empty[g] & is_com(w_head[g]);
    end

    always_comb begin
        w_min_count = w_count[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (w_count[i] < w_min_count) w_min_count = w_count[i];
        end
    end

    assign w_all_ready   = (w_min_count != '0);
    assign w_all_com     = w_all_ready & (&w_com);
    assign w_hold_ovf    = |(w_com & w_full & valid_in);
    assign w_ovf         = |(w_full & valid_in);
    assign w_misalign    = w_all_ready & (|w_com) & ~(&w_com);
    // Reaching alignment wins over a holding-lane overflow in the same cycle.
    assign w_hunt_err    = deskew_en & (r_state == HUNT) & ~w_all_com & w_hold_ovf;
    assign w_aligned_err = deskew_en & (r_state == ALIGNED) & (w_ovf | w_misalign);
    assign w_flush       = ~deskew_en | (r_state == IDLE) | w_hunt_err | w_aligned_err;
    assign w_push        = valid_in & {NUM_LANES{deskew_en && (r_state != IDLE)}};

    always_comb begin
        w_pop = '0;
        case (r_state)
            HUNT:    w_pop = ~w_empty & ~w_com;
            ALIGNED: w_pop = {NUM_LANES{w_all_ready}};
            default: w_pop = '0;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_data_out     <= '0;
            r_valid_out    <= 1'b0;
            r_aligned      <= 1'b0;
            r_deskew_error <= 1'b0;
            r_lock_fail    <= 1'b0;
            r_fail_cnt     <= '0;
        end else if (!deskew_en) begin
            r_state        <= IDLE;
            r_valid_out    <= 1'b0;
            r_aligned      <= 1'b0;
            r_deskew_error <= 1'b0;
            r_lock_fail    <= 1'b0;
            r_fail_cnt     <= '0;
        end else begin
            r_valid_out    <= 1'b0;
            r_deskew_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state   <= HUNT;
                    r_aligned <= 1'b0;
                end
                HUNT: begin
                    if (w_all_com) begin
                        r_state    <= ALIGNED;
                        r_aligned  <= 1'b1;
                        r_fail_cnt <= '0;
                    end else if (w_hold_ovf) begin
                        r_deskew_error <= 1'b1;
                        if (r_fail_cnt != FW'(ERR_LIMIT)) r_fail_cnt <= r_fail_cnt + FW'(1);
                        if (r_fail_cnt >= FW'(ERR_LIMIT - 1)) r_lock_fail <= 1'b1;
                    end
                end
                ALIGNED: begin
                    if (w_ovf || w_misalign) begin
                        r_state        <= HUNT;
                        r_aligned      <= 1'b0;
                        r_deskew_error <= 1'b1;
                    end else if (w_all_ready) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            r_data_out[i*DATA_WIDTH +: DATA_WIDTH] <= w_head[i];
                        end
                        r_valid_out <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_aligned <= 1'b0;
                end
            endcase
        end
    end

`ifdef DESKEW_STATS_EN
    logic [NUM_LANES*CW-1:0] r_lane_skew;

    // Snapshot relative occupancy at the moment all lanes first agree on COM.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_lane_skew <= '0;
        end else if (deskew_en && (r_state == HUNT) && w_all_com) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lane_skew[i*CW +: CW] <= w_count[i] - w_min_count;
            end
        end
    end

    assign lane_skew = r_lane_skew;
`endif

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign aligned      = r_aligned;
    assign deskew_error = r_deskew_error;
    assign lock_fail    = r_lock_fail;

endmodule

// File: tb/tb_multi_lane_deskew_buffer.sv
// Directed bench for multi_lane_deskew_buffer: per-lane symbol sources with
// programmable skew, hold and drop; output words checked against the sequence.
module tb_multi_lane_deskew_buffer;
    import deskew_pkg::*;

    localparam int DW = 10;
    localparam int NL = 4;
    localparam int CW = 4;

    logic              read_clk = 1'b0;
    logic              rst;
    logic              deskew_en;
    logic [NL*DW-1:0]  data_in;
    logic [NL-1:0]     valid_in;
    logic [NL*DW-1:0]  data_out;
    logic              valid_out;
    logic              aligned;
    logic              deskew_error;
    logic              lock_fail;
`ifdef DESKEW_STATS_EN
    logic [NL*CW-1:0]  lane_skew;
`endif

    multi_lane_deskew_buffer #(
        .DATA_WIDTH   (DW),
        .NUM_LANES    (NL),
        .BUFFER_DEPTH (8),
        .ERR_LIMIT    (3)
    ) dut (
        .read_clk     (read_clk),
        .rst          (rst),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .deskew_en    (deskew_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .aligned      (aligned),
        .deskew_error (deskew_error),
        .lock_fail    (lock_fail)
`ifdef DESKEW_STATS_EN
        ,
        .lane_skew    (lane_skew)
`endif
    );

    always #5 read_clk = ~read_clk;

    int n_vec  = 0;
    int n_miss = 0;
    int lane_n [NL];
    bit lane_hold [NL];
    bit lane_go;
    bit chk_words;
    bit have_prev;
    int exp_idx;
    int err_seen;

    // Stream symbol n: COM every 16 symbols, otherwise 0x100 + (n mod 16).
    function automatic logic [DW-1:0] sym(input int n);
        int m;
        m = n % 16;
        if (m == 0) return COM_RDN;
        return 10'h100 + 10'(m);
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        for (int i = 0; i < NL; i++) begin
            if (lane_go && !lane_hold[i] && lane_n[i] >= 0) begin
                data_in[i*DW +: DW] = sym(lane_n[i]);
                valid_in[i]         = 1'b1;
            end else begin
                data_in[i*DW +: DW] = '0;
                valid_in[i]         = 1'b0;
            end
        end
        @(posedge read_clk);
        #1;
        if (lane_go) begin
            for (int i = 0; i < NL; i++) if (!lane_hold[i]) lane_n[i]++;
        end
        if (deskew_error) err_seen++;
        if (!aligned || !chk_words) begin
            have_prev = 1'b0;
        end else if (valid_out) begin
            exp_idx   = have_prev ? (exp_idx + 1) % 16 : 0;
            have_prev = 1'b1;
            check_val("word", data_out, {NL{sym(exp_idx)}});
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int cnt;
        int k;
        int errs_at_lock;
        bit saw_low;
        bit saw_al;

        rst = 1'b1; deskew_en = 1'b0; lane_go = 1'b0; chk_words = 1'b1;
        have_prev = 1'b0; exp_idx = 0; err_seen = 0;
        data_in = '0; valid_in = '0;
        for (int i = 0; i < NL; i++) begin lane_n[i] = 0; lane_hold[i] = 1'b0; end
        run(2);
        check_val("rst_data_out", data_out, 0);
        check_val("rst_valid_out", valid_out, 0);
        check_val("rst_aligned", aligned, 0);
        check_val("rst_error", deskew_error, 0);
        check_val("rst_lock_fail", lock_fail, 0);
        rst = 1'b0;

        // Zero skew: COM reaches all lanes on the 5th step.
        deskew_en = 1'b1; err_seen = 0;
        for (int i = 0; i < NL; i++) lane_n[i] = -4;
        lane_go = 1'b1;
        run(5);
        check_val("t1_not_yet_aligned", aligned, 0);
        step();
        check_val("t1_aligned", aligned, 1);
        check_val("t1_valid_before", valid_out, 0);
        step();
        check_val("t1_first_valid", valid_out, 1);
        check_val("t1_first_com", data_out, {NL{COM_RDN}});
        run(20);
        check_val("t1_no_error", err_seen, 0);

        // Lane 1 bubble of 3 cycles; one spare symbol per lane absorbs the first.
        err_seen = 0; cnt = 0;
        lane_hold[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin step(); if (!valid_out) cnt++; end
        lane_hold[1] = 1'b0;
        for (int j = 0; j < 5; j++) begin step(); if (!valid_out) cnt++; end
        check_val("t5_gap_cycles", cnt, 2);
        run(20);
        check_val("t5_no_error", err_seen, 0);
        check_val("t5_still_aligned", aligned, 1);

        // Lane 2 loses one symbol: one error, then realign at the next COM.
        chk_words = 1'b0; err_seen = 0; saw_low = 1'b0;
        lane_n[2]++;
        for (k = 0; k < 80; k++) begin
            step();
            if (!aligned) saw_low = 1'b1;
            if (saw_low && aligned) break;
        end
        check_val("t4_error_pulses", err_seen, 1);
        check_val("t4_dropped_align", saw_low, 1);
        check_val("t4_realigned", aligned, 1);
        chk_words = 1'b1;
        run(20);
        check_val("t4_no_more_error", err_seen, 1);

        // Synchronous reset mid-stream.
        rst = 1'b1;
        step();
        check_val("t6_rst_data_out", data_out, 0);
        check_val("t6_rst_valid_out", valid_out, 0);
        check_val("t6_rst_aligned", aligned, 0);
        check_val("t6_rst_error", deskew_error, 0);
        check_val("t6_rst_lock_fail", lock_fail, 0);
        rst = 1'b0; lane_go = 1'b0; cnt = 0;
        for (int j = 0; j < 10; j++) begin step(); if (aligned || valid_out) cnt++; end
        check_val("t6_rst_empty", cnt, 0);

        // Skew {0,2,5,1}: lane 2 sends COM on step 14, aligned after step 15.
        err_seen = 0;
        lane_n[0] = 8; lane_n[1] = 6; lane_n[2] = 3; lane_n[3] = 7;
        lane_go = 1'b1;
        for (k = 1; k <= 40; k++) begin
            step();
            if (aligned) break;
        end
        check_val("t2_aligned", aligned, 1);
        check_val("t2_align_step", k, 15);
`ifdef DESKEW_STATS_EN
        check_val("t2_lane_skew", lane_skew, {4'd4, 4'd0, 4'd3, 4'd5});
`endif
        run(30);
        check_val("t2_no_error", err_seen, 0);

        // deskew_en falls mid-stream.
        deskew_en = 1'b0;
        step();
        check_val("t6_en_valid_out", valid_out, 0);
        check_val("t6_en_aligned", aligned, 0);
        check_val("t6_en_error", deskew_error, 0);
        lane_go = 1'b0; deskew_en = 1'b1; cnt = 0;
        for (int j = 0; j < 8; j++) begin step(); if (aligned || valid_out) cnt++; end
        check_val("t6_en_empty", cnt, 0);

        // Lane 3 lags by 8 symbols: repeated overflow until lock_fail.
        err_seen = 0; saw_al = 1'b0; errs_at_lock = -1;
        lane_n[0] = 9; lane_n[1] = 9; lane_n[2] = 9; lane_n[3] = 1;
        lane_go = 1'b1;
        for (k = 0; k < 150; k++) begin
            step();
            if (aligned) saw_al = 1'b1;
            if (lock_fail) begin errs_at_lock = err_seen; break; end
        end
        check_val("t3_lock_fail", lock_fail, 1);
        check_val("t3_errs_at_lock", errs_at_lock, 3);
        check_val("t3_never_aligned", saw_al, 0);
        run(20);
        check_val("t3_lock_sticky", lock_fail, 1);
        check_val("t3_hunt_continues", err_seen > 3, 1);
        deskew_en = 1'b0;
        step();
        check_val("t3_lock_cleared", lock_fail, 0);
        check_val("t3_idle_aligned", aligned, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
